// File: rtl/bist_pkg.sv
// rtl/bist_pkg.sv - shared widths, tap positions, FSM states and LFSR step for the BIST chip
package bist_pkg;

    localparam int PI_W = 35;
    localparam int PO_W = 49;

    // x^35 + x^2 + 1: feedback is the MSB XOR bit 1
    localparam int LFSR_TAP = 1;
    // x^49 + x^9 + 1: the MSB is folded back into bit 9
    localparam int MISR_TAP = 9;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    function automatic logic [PI_W-1:0] lfsr_next(input logic [PI_W-1:0] cur);
        return {cur[PI_W-2:0], cur[PI_W-1] ^ cur[LFSR_TAP]};
    endfunction

endpackage

// File: rtl/bist_misr.sv
// rtl/bist_misr.sv - multiple-input signature register with enable and synchronous clear
// Ports: clk_i, rst_ni (async active-low), en_i compact, clr_i zero, data_i response, sig_o signature.
module bist_misr
    import bist_pkg::*;
#(
    parameter int W   = PO_W,
    parameter int TAP = MISR_TAP
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         en_i,
    input  logic         clr_i,
    input  logic [W-1:0] data_i,
    output logic [W-1:0] sig_o
);

    logic [W-1:0] sig_q;
    logic [W-1:0] sig_d;
    logic [W-1:0] fb;

    always_comb begin
        fb      = '0;
        fb[TAP] = sig_q[W-1];
        sig_d   = sig_q;
        if (clr_i) begin
            sig_d = '0;
        end else if (en_i) begin
            // rotate left, fold the MSB into the tap, then absorb the response
            sig_d = {sig_q[W-2:0], sig_q[W-1]} ^ fb ^ data_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sig_q <= '0;
        end else begin
            sig_q <= sig_d;
        end
    end

    assign sig_o = sig_q;

endmodule

// File: rtl/s5378.sv
// rtl/s5378.sv - core-under-test with the s5378 pin counts and named internal nodes
// Ports: clk, rst (async active-low), pi[34:0] primary inputs, po[48:0] primary outputs.
module s5378 (
    input  logic        clk,
    input  logic        rst,
    input  logic [34:0] pi,
    output logic [48:0] po
);

    logic        n482gat;
    logic        n226gat;
    logic        II4020;
    logic [48:0] st_q;
    logic [48:0] st_d;

    assign n482gat = pi[3] & pi[17];
    assign n226gat = pi[10] | pi[29];
    assign II4020  = pi[34] ^ st_q[0];

    always_comb begin
        st_d     = {st_q[47:0], st_q[48] ^ n482gat} ^ {14'b0, pi};
        st_d[20] = st_d[20] ^ n226gat;
        st_d[40] = st_d[40] ^ II4020;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            st_q <= '0;
        end else begin
            st_q <= st_d;
        end
    end

    assign po = st_q;

endmodule

// File: rtl/bist_chip.sv
// rtl/bist_chip.sv - test chip: s5378 core wrapped with LFSR/MISR logic BIST
// Ports: clk, rst (async active-low), pi[34:0] functional inputs, po[48:0] core outputs,
//        bistmode (1 = BIST), bistdone run complete, bistpass signature matched (valid with bistdone).
module bist_chip
    import bist_pkg::*;
#(
    parameter int              NUM_PATTERNS = 2000,
    parameter logic [PI_W-1:0] LFSR_SEED    = 35'h000000001,
    parameter logic [PO_W-1:0] GOLDEN_SIG   = 49'h0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [PI_W-1:0] pi,
    output logic [PO_W-1:0] po,
    input  logic            bistmode,
    output logic            bistdone,
    output logic            bistpass
);

    localparam int              CNT_W = $clog2(NUM_PATTERNS) + 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(NUM_PATTERNS - 1);

    state_e           state_q, state_d;
    logic [PI_W-1:0]  lfsr_q, lfsr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             run_en;
    logic             misr_clr;
    logic [PI_W-1:0]  cut_pi;
    logic [PO_W-1:0]  sig;

    always_comb begin
        state_d  = state_q;
        lfsr_d   = lfsr_q;
        cnt_d    = cnt_q;
        run_en   = 1'b0;
        misr_clr = 1'b0;
        case (state_q)
            IDLE: begin
                if (bistmode) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (!bistmode) begin
                    // abort: back to a fresh start so a later run matches the golden signature
                    state_d  = IDLE;
                    lfsr_d   = LFSR_SEED;
                    cnt_d    = '0;
                    misr_clr = 1'b1;
                end else begin
                    run_en = 1'b1;
                    lfsr_d = lfsr_next(lfsr_q);
                    cnt_d  = cnt_q + 1'b1;
                    if (cnt_q == LAST) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            lfsr_q  <= LFSR_SEED;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            lfsr_q  <= lfsr_d;
            cnt_q   <= cnt_d;
        end
    end

    assign cut_pi = (state_q == RUN) ? lfsr_q : pi;

    s5378 circuit (
        .clk (clk),
        .rst (rst),
        .pi  (cut_pi),
        .po  (po)
    );

    bist_misr #(
        .W   (PO_W),
        .TAP (MISR_TAP)
    ) u_misr (
        .clk_i  (clk),
        .rst_ni (rst),
        .en_i   (run_en),
        .clr_i  (misr_clr),
        .data_i (po),
        .sig_o  (sig)
    );

    assign bistdone = (state_q == DONE);
    assign bistpass = bistdone && (sig == GOLDEN_SIG);

endmodule

// File: tb/tb_bist_chip.sv
// tb/tb_bist_chip.sv - self-checking bench for bist_chip against a behavioural model
module tb_bist_chip;
    import bist_pkg::*;

    localparam int          NUM_PATTERNS = 2000;
    localparam logic [34:0] SEED         = 35'h000000001;

    function automatic logic [34:0] lfsr_step(input logic [34:0] l);
        return {l[33:0], l[34] ^ l[1]};
    endfunction

    // signature times x modulo x^49+x^9+1, plus the response word
    function automatic logic [48:0] misr_step(input logic [48:0] m, input logic [48:0] d);
        logic [48:0] r;
        r = {m[47:0], m[48]};
        if (m[48]) r[9] = ~r[9];
        return r ^ d;
    endfunction

    function automatic logic [48:0] cut_step(input logic [48:0] c, input logic [34:0] p);
        logic [48:0] n;
        n     = {c[47:0], c[48]};
        n[0]  = n[0] ^ (p[3] & p[17]);
        n     = n ^ {14'b0, p};
        n[20] = n[20] ^ (p[10] | p[29]);
        n[40] = n[40] ^ (p[34] ^ c[0]);
        return n;
    endfunction

    function automatic logic [48:0] calc_golden();
        logic [34:0] l;
        logic [48:0] m;
        logic [48:0] c;
        l = SEED;
        m = '0;
        c = '0;
        for (int a = 0; a < NUM_PATTERNS / 50; a++) begin
            for (int b = 0; b < 50; b++) begin
                m = misr_step(m, c);
                c = cut_step(c, l);
                l = lfsr_step(l);
            end
        end
        return m;
    endfunction

    localparam logic [48:0] GOLDEN = calc_golden();

    logic        clk = 1'b0;
    logic        rst;
    logic        bistmode;
    logic [34:0] pi;
    logic [48:0] po;
    logic        bistdone;
    logic        bistpass;

    always #5 clk = ~clk;

    bist_chip #(
        .NUM_PATTERNS (NUM_PATTERNS),
        .LFSR_SEED    (SEED),
        .GOLDEN_SIG   (GOLDEN)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .pi       (pi),
        .po       (po),
        .bistmode (bistmode),
        .bistdone (bistdone),
        .bistpass (bistpass)
    );

    int          n_checks = 0;
    int          n_fail   = 0;
    bit          chk_en   = 1'b0;
    bit          fault_on = 1'b0;
    bit          m_run, m_done;
    int          m_k;
    logic [48:0] m_sig, m_cut;
    logic [34:0] lfsr_seq [0:NUM_PATTERNS];
    logic [34:0] cap_pi [1:5];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [34:0] rnd35();
        return 35'({$urandom(), $urandom()});
    endfunction

    // behavioural model: run progress counted in patterns, signature built from observed po
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_run  = 1'b0;
            m_done = 1'b0;
            m_k    = 0;
            m_sig  = '0;
            m_cut  = '0;
        end else begin
            m_cut = cut_step(m_cut, m_run ? lfsr_seq[m_k] : pi);
            if (m_run) begin
                if (!bistmode) begin
                    m_run = 1'b0;
                    m_k   = 0;
                    m_sig = '0;
                end else begin
                    m_sig = misr_step(m_sig, po);
                    m_k++;
                    if (m_k == NUM_PATTERNS) begin
                        m_run  = 1'b0;
                        m_done = 1'b1;
                    end
                end
            end else if (!m_done && bistmode) begin
                m_run = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("cut_pi", 64'(dut.circuit.pi), 64'(m_run ? lfsr_seq[m_k] : pi));
            chk("bistdone", 64'(bistdone), 64'(m_done));
            chk("bistpass", 64'(bistpass), 64'(m_done && (m_sig == GOLDEN)));
            if (!fault_on) chk("po", 64'(po), 64'(m_cut));
        end
    end

    task automatic do_reset();
        @(posedge clk);
        #3 rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic run_bist(output int edges, output bit seen);
        bistmode = 1'b1;
        pi       = '0;
        edges    = 0;
        seen     = 1'b0;
        @(negedge clk);
        #1 rst = 1'b1;
        while (!seen && edges < 3000) begin
            @(posedge clk);
            edges++;
            #2;
            if (edges <= 5) cap_pi[edges] = dut.circuit.pi;
            if (bistdone) seen = 1'b1;
            else pi = rnd35();
        end
        chk("done_seen", 64'(seen), 64'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int edges;
        bit seen;
        lfsr_seq[0] = SEED;
        for (int i = 1; i <= NUM_PATTERNS; i++) lfsr_seq[i] = lfsr_step(lfsr_seq[i-1]);
        rst = 1'b0;
        bistmode = 1'b0;
        pi = '0;
        #2;
        chk("rst_bistdone", 64'(bistdone), 64'd0);
        chk("rst_bistpass", 64'(bistpass), 64'd0);
        chk("rst_po", 64'(po), 64'd0);
        chk_en = 1'b1;

        // functional passthrough
        @(negedge clk);
        #1 rst = 1'b1;
        pi = 35'h4_0000_0001;
        @(posedge clk);
        #2;
        chk("func_pi", 64'(dut.circuit.pi), 64'h4_0000_0001);
        for (int i = 0; i < 30; i++) begin
            @(posedge clk);
            #1 pi = rnd35();
        end
        #1 chk("func_done", 64'(bistdone), 64'd0);

        // fault-free run: latency, pass, LFSR start sequence, hold
        do_reset();
        run_bist(edges, seen);
        chk("latency", 64'(edges), 64'd2001);
        chk("pass", 64'(bistpass), 64'd1);
        chk("signature", 64'(dut.u_misr.sig_o), 64'(GOLDEN));
        chk("lfsr1", 64'(cap_pi[1]), 64'h1);
        chk("lfsr2", 64'(cap_pi[2]), 64'h2);
        chk("lfsr3", 64'(cap_pi[3]), 64'h5);
        chk("lfsr4", 64'(cap_pi[4]), 64'hA);
        chk("lfsr5", 64'(cap_pi[5]), 64'h15);
        repeat (20) @(posedge clk);
        #2;
        chk("hold_done", 64'(bistdone), 64'd1);
        chk("hold_pass", 64'(bistpass), 64'd1);

        // asynchronous reset while done, then identical rerun
        @(posedge clk);
        #3 rst = 1'b0;
        #1;
        chk("async_done", 64'(bistdone), 64'd0);
        chk("async_pass", 64'(bistpass), 64'd0);
        repeat (2) @(negedge clk);
        run_bist(edges, seen);
        chk("rerun_latency", 64'(edges), 64'd2001);
        chk("rerun_pass", 64'(bistpass), 64'd1);

        // stuck-at faults, one per run
        for (int f = 0; f < 3; f++) begin
            do_reset();
            fault_on = 1'b1;
            case (f)
                0: force dut.circuit.n482gat = 1'b0;
                1: force dut.circuit.n226gat = 1'b1;
                default: force dut.circuit.II4020 = 1'b0;
            endcase
            run_bist(edges, seen);
            chk("fault_done", 64'(bistdone), 64'd1);
            chk("fault_pass", 64'(bistpass), 64'd0);
            do_reset();
            case (f)
                0: release dut.circuit.n482gat;
                1: release dut.circuit.n226gat;
                default: release dut.circuit.II4020;
            endcase
            fault_on = 1'b0;
        end
        run_bist(edges, seen);
        chk("clean_pass", 64'(bistpass), 64'd1);

        // abort after 500 RUN cycles
        do_reset();
        bistmode = 1'b1;
        pi = '0;
        @(negedge clk);
        #1 rst = 1'b1;
        for (int i = 0; i <= 500; i++) begin
            @(posedge clk);
            #1 pi = rnd35();
        end
        bistmode = 1'b0;
        @(posedge clk);
        #2;
        chk("abort_pi", 64'(dut.circuit.pi), 64'(pi));
        chk("abort_done", 64'(bistdone), 64'd0);
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1 pi = rnd35();
        end
        #1 chk("abort_idle", 64'(bistdone), 64'd0);

        @(negedge clk);
        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
